ascon_init: RTL and testbench
=============================

ASCON_INIT -- requirements
Module: ascon_init

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request to begin initialization; accepted only when in_ready=1.
REQ-004 in_ready  output  1  high only in IDLE.
REQ-005 key  input  128  Ascon-128 key K; key[127:64] is the high word.
REQ-006 nonce  input  128  nonce N; nonce[127:64] is the high word.
REQ-007 out_valid  output  1  y0..y4 hold the initialized state.
REQ-008 out_ready  input  1  downstream associated-data stage accepts the state.
REQ-009 y0, y1, y2, y3, y4  output  64 each  320-bit state after initialization, fed to the AD stage.
REQ-010 busy  output  1  high in ROUND state.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, ROUND and DONE.
REQ-012 When start=1 in IDLE, the block SHALL load at that edge: x0=64'h80400c0600000000, x1=key[127:64], x2=key[63:0], x3=nonce[127:64], x4=nonce[63:0]; clear round counter r to 0; register key internally; enter ROUND.
REQ-013 key and nonce SHALL be sampled only at the accepting edge; later input changes SHALL have no effect.
REQ-014 In ROUND, each edge SHALL apply one Ascon round with constant c_r = {4'hf - r[3:0], r[3:0]} (8 bits, zero-extended), r=0..11 (first 8'hf0, last 8'h4b), then increment r.
REQ-015 Each round SHALL be: x2 ^= c_r; 5-bit S-box per bit column (x0 = MSB), table 4,b,1f,14,1a,15,9,2,1b,5,8,12,1d,3,6,1c,1e,13,7,e,0,d,11,18,10,c,1,19,16,a,f,17 (hex); linear layer xi ^= ROR(xi,a) ^ ROR(xi,b) with (a,b) = (19,28),(61,39),(1,6),(10,17),(7,41) for x0..x4.
REQ-016 The edge applying round r=11 SHALL also XOR x3 ^= K[127:64], x4 ^= K[63:0] on the post-round state, and enter DONE.
REQ-017 Latency: accepting edge E0; rounds on E1..E12; out_valid=1 from immediately after E12; exactly 12 cycles in ROUND.
REQ-018 In DONE, out_valid=1 and y0..y4 SHALL stay stable until out_ready=1 is sampled; then the block SHALL return to IDLE at that edge.
REQ-019 out_valid=1 with out_ready=0 SHALL hold indefinitely without state change.
REQ-020 start SHALL be ignored in ROUND and DONE, including the DONE edge where out_ready=1; a new start is accepted no earlier than the following IDLE cycle.
REQ-021 y0..y4 SHALL continuously reflect the internal state register; values are meaningful only when out_valid=1.
REQ-022 r SHALL be 4 bits, never exceed 11, and SHALL NOT wrap back to 0 within ROUND.
REQ-023 Back-to-back operation: with start held high, a new initialization SHALL begin on the first IDLE edge after the handshake, giving one operation per 14 cycles minimum.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, r=0, state and key registers to zero, out_valid=0, busy=0, in_ready=1 (after deassertion).
REQ-025 Reset asserted mid-ROUND or in DONE SHALL abort without completing the handshake; no out_valid pulse after release.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Verification
REQ-027 key=nonce=0x000102030405060708090a0b0c0d0e0f, out_ready=1 -> out_valid asserted exactly 12 cycles after accept; y0..y4 bit-exact to the golden Ascon-128 software model post-init state.
REQ-028 key=nonce=0 -> y0..y4 match golden model; busy high for exactly 12 cycles; in_ready low from E0 until the handshake edge.
REQ-029 out_ready=0 for 20 cycles after out_valid -> y0..y4 constant, out_valid held; out_ready=1 -> IDLE next cycle.
REQ-030 Change key/nonce to 0xff..ff and pulse start during ROUND -> output still matches the originally sampled vector; second start ignored.
REQ-031 Assert rst_n=0 at round r=6 -> all outputs zero immediately; after release, a fresh start yields a correct result with 12-cycle latency.
REQ-032 start held high with out_ready=1 across 3 operations using different keys -> 3 correct outputs, each 14 cycles apart.

Source files
------------

// File: rtl/ascon_init.sv
// Ascon-128 initialization: loads IV/key/nonce, runs the 12-round permutation
// one round per clock, folds the key into x3/x4, then hands the state downstream.
module ascon_init (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  y0,
  output logic [63:0]  y1,
  output logic [63:0]  y2,
  output logic [63:0]  y3,
  output logic [63:0]  y4,
  output logic         busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [63:0] IV = 64'h80400c0600000000;

  logic [1:0]   state_q, state_d;
  logic [3:0]   r_q, r_d;
  logic [63:0]  x0_q, x1_q, x2_q, x3_q, x4_q;
  logic [63:0]  x0_d, x1_d, x2_d, x3_d, x4_d;
  logic [127:0] key_q, key_d;

  logic [7:0]   c_r;
  logic [63:0]  a2;
  logic [63:0]  s0, s1, s2, s3, s4;
  logic [63:0]  l0, l1, l2, l3, l4;
  logic [4:0]   col;

  function automatic logic [4:0] sbox(input logic [4:0] v);
    logic [4:0] o;
    o = 5'h00;
    case (v)
      5'h00: o = 5'h04;  5'h01: o = 5'h0b;  5'h02: o = 5'h1f;  5'h03: o = 5'h14;
      5'h04: o = 5'h1a;  5'h05: o = 5'h15;  5'h06: o = 5'h09;  5'h07: o = 5'h02;
      5'h08: o = 5'h1b;  5'h09: o = 5'h05;  5'h0a: o = 5'h08;  5'h0b: o = 5'h12;
      5'h0c: o = 5'h1d;  5'h0d: o = 5'h03;  5'h0e: o = 5'h06;  5'h0f: o = 5'h1c;
      5'h10: o = 5'h1e;  5'h11: o = 5'h13;  5'h12: o = 5'h07;  5'h13: o = 5'h0e;
      5'h14: o = 5'h00;  5'h15: o = 5'h0d;  5'h16: o = 5'h11;  5'h17: o = 5'h18;
      5'h18: o = 5'h10;  5'h19: o = 5'h0c;  5'h1a: o = 5'h01;  5'h1b: o = 5'h19;
      5'h1c: o = 5'h16;  5'h1d: o = 5'h0a;  5'h1e: o = 5'h0f;  5'h1f: o = 5'h17;
      default: o = 5'h00;
    endcase
    return o;
  endfunction

  // One full round: constant addition, column-wise S-box (x0 is the MSB), linear diffusion.
  always_comb begin
    c_r = {4'hf - r_q, r_q};
    a2  = x2_q ^ {56'h0, c_r};
    s0  = '0;
    s1  = '0;
    s2  = '0;
    s3  = '0;
    s4  = '0;
    col = '0;
    for (int i = 0; i < 64; i++) begin
      col   = sbox({x0_q[i], x1_q[i], a2[i], x3_q[i], x4_q[i]});
      s0[i] = col[4];
      s1[i] = col[3];
      s2[i] = col[2];
      s3[i] = col[1];
      s4[i] = col[0];
    end
    l0 = s0 ^ {s0[18:0], s0[63:19]} ^ {s0[27:0], s0[63:28]};
    l1 = s1 ^ {s1[60:0], s1[63:61]} ^ {s1[38:0], s1[63:39]};
    l2 = s2 ^ {s2[0],    s2[63:1]}  ^ {s2[5:0],  s2[63:6]};
    l3 = s3 ^ {s3[9:0],  s3[63:10]} ^ {s3[16:0], s3[63:17]};
    l4 = s4 ^ {s4[6:0],  s4[63:7]}  ^ {s4[40:0], s4[63:41]};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    key_d   = key_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    x3_d    = x3_q;
    x4_d    = x4_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = IV;
          x1_d    = key[127:64];
          x2_d    = key[63:0];
          x3_d    = nonce[127:64];
          x4_d    = nonce[63:0];
          key_d   = key;
          r_d     = 4'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        x0_d = l0;
        x1_d = l1;
        x2_d = l2;
        x3_d = l3;
        x4_d = l4;
        // r parks at 11 on the final round rather than wrapping.
        if (r_q == 4'd11) begin
          x3_d    = l3 ^ key_q[127:64];
          x4_d    = l4 ^ key_q[63:0];
          state_d = DONE;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= 4'd0;
      key_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      x4_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      key_q   <= key_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      x3_q    <= x3_d;
      x4_q    <= x4_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == ROUND);
  assign out_valid = (state_q == DONE);
  assign y0 = x0_q;
  assign y1 = x1_q;
  assign y2 = x2_q;
  assign y3 = x3_q;
  assign y4 = x4_q;

endmodule

// File: tb/tb_ascon_init.sv
// Bench for ascon_init: directed and random initializations checked against a
// bitsliced Ascon reference model, plus handshake, hold, abort and back-to-back cases.
module tb_ascon_init;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         out_ready;
  logic [127:0] key;
  logic [127:0] nonce;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [63:0]  y0, y1, y2, y3, y4;
  logic [319:0] y_all;

  int n_checks;
  int n_fail;

  assign y_all = {y0, y1, y2, y3, y4};

  ascon_init dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_ready  (in_ready),
    .key       (key),
    .nonce     (nonce),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference Ascon initialization using the standard bitsliced S-box formulation.
  function automatic logic [319:0] ref_init(input logic [127:0] k, input logic [127:0] n);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = 64'h80400c0600000000;
    x1 = k[127:64];
    x2 = k[63:0];
    x3 = n[127:64];
    x4 = n[63:0];
    for (int r = 0; r < 12; r++) begin
      x2 ^= 64'(240 - 15 * r);
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
      x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
      x2 ^= rotr(x2, 1)  ^ rotr(x2, 6);
      x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
      x4 ^= rotr(x4, 7)  ^ rotr(x4, 41);
    end
    x3 ^= k[127:64];
    x4 ^= k[63:0];
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [127:0] k, input logic [127:0] n, input string tag);
    key   = k;
    nonce = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_accept"}, {318'h0, in_ready, busy}, 320'b01);
  endtask

  // Waits for out_valid (bounded), checking latency, busy-cycle count, in_ready low and result.
  task automatic wait_valid(input int exp_lat, input logic [319:0] exp, input string tag);
    int cnt, bcnt, rcnt;
    cnt  = 0;
    bcnt = int'(busy);
    rcnt = int'(in_ready);
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
      bcnt += int'(busy);
      rcnt += int'(in_ready);
    end
    chk({tag, "_lat"},   320'(cnt),  320'(exp_lat));
    chk({tag, "_busy"},  320'(bcnt), 320'(exp_lat));
    chk({tag, "_irdy"},  320'(rcnt), 320'd0);
    chk({tag, "_state"}, y_all, exp);
  endtask

  task automatic finish_hs(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_idle"}, {318'h0, in_ready, out_valid}, 320'b10);
  endtask

  logic [319:0] exp;
  logic [127:0] kk [3];
  logic [127:0] nn [3];
  logic [319:0] ee [3];
  int           vt [3];
  int           j;
  int           vcnt;
  int           d;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    key       = '0;
    nonce     = '0;
    tick();
    tick();
    chk("rst_ctrl", {317'h0, in_ready, out_valid, busy}, 320'b100);
    chk("rst_y", y_all, 320'h0);
    rst_n = 1'b1;
    tick();

    // Standard test vector with downstream always ready
    out_ready = 1'b1;
    exp = ref_init(128'h000102030405060708090a0b0c0d0e0f, 128'h000102030405060708090a0b0c0d0e0f);
    start_op(128'h000102030405060708090a0b0c0d0e0f, 128'h000102030405060708090a0b0c0d0e0f, "kat");
    wait_valid(12, exp, "kat");
    tick();
    chk("kat_idle", {318'h0, in_ready, out_valid}, 320'b10);

    // All-zero key and nonce
    exp = ref_init('0, '0);
    start_op('0, '0, "zero");
    wait_valid(12, exp, "zero");
    tick();
    chk("zero_idle", {318'h0, in_ready, out_valid}, 320'b10);

    // Downstream stalls 20 cycles: output must hold
    out_ready = 1'b0;
    kk[0] = rand128();
    nn[0] = rand128();
    exp = ref_init(kk[0], nn[0]);
    start_op(kk[0], nn[0], "hold");
    wait_valid(12, exp, "hold");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_y", y_all, exp);
      chk("hold_valid", {319'h0, out_valid}, 320'b1);
    end
    finish_hs("hold");

    // Inputs change and start pulses mid-operation; must be ignored
    out_ready = 1'b0;
    kk[0] = rand128();
    nn[0] = rand128();
    exp = ref_init(kk[0], nn[0]);
    start_op(kk[0], nn[0], "perturb");
    key   = '1;
    nonce = '1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    wait_valid(8, exp, "perturb");
    tick();
    chk("perturb_done_hold", {318'h0, out_valid, busy}, 320'b10);
    chk("perturb_done_y", y_all, exp);
    out_ready = 1'b1;
    tick();
    chk("perturb_hs_edge", {317'h0, in_ready, busy, out_valid}, 320'b100);
    start = 1'b0;
    tick();

    // Reset at round 6 aborts the operation
    kk[0] = rand128();
    nn[0] = rand128();
    start_op(kk[0], nn[0], "abort");
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {317'h0, in_ready, out_valid, busy}, 320'b100);
    chk("abort_y", y_all, 320'h0);
    tick();
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      vcnt += int'(out_valid) + int'(busy);
    end
    chk("abort_no_valid", 320'(vcnt), 320'd0);
    kk[0] = rand128();
    nn[0] = rand128();
    exp = ref_init(kk[0], nn[0]);
    start_op(kk[0], nn[0], "post_abort");
    wait_valid(12, exp, "post_abort");
    tick();

    // Random operations with random downstream delay
    for (int t = 0; t < 4; t++) begin
      out_ready = 1'b0;
      kk[0] = rand128();
      nn[0] = rand128();
      exp = ref_init(kk[0], nn[0]);
      start_op(kk[0], nn[0], "rand");
      wait_valid(12, exp, "rand");
      d = int'($urandom_range(0, 3));
      for (int i = 0; i < d; i++) begin
        tick();
        chk("rand_hold_y", y_all, exp);
      end
      finish_hs("rand");
    end

    // Back-to-back with start held high: one result every 14 cycles
    for (int i = 0; i < 3; i++) begin
      kk[i] = rand128();
      nn[i] = rand128();
      ee[i] = ref_init(kk[i], nn[i]);
      vt[i] = 0;
    end
    out_ready = 1'b1;
    key   = kk[0];
    nonce = nn[0];
    start = 1'b1;
    tick();
    key   = kk[1];
    nonce = nn[1];
    j = 0;
    for (int i = 1; i <= 42; i++) begin
      tick();
      if (out_valid) begin
        if (j < 3) begin
          chk("b2b_state", y_all, ee[j]);
          vt[j] = i;
        end
        j++;
      end
      if (i == 14) begin
        key   = kk[2];
        nonce = nn[2];
      end
      if (i == 28) start = 1'b0;
    end
    chk("b2b_count", 320'(j), 320'd3);
    chk("b2b_first", 320'(vt[0]), 320'd12);
    chk("b2b_gap1", 320'(vt[1] - vt[0]), 320'd14);
    chk("b2b_gap2", 320'(vt[2] - vt[1]), 320'd14);
    chk("b2b_idle", {318'h0, in_ready, busy}, 320'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
